decoder_scan_sequencer: RTL and testbench

//  Upstream driver for decoder_4x16. Walks the 16 decoder lines in ascending order,

---
 rtl/decoder_pkg.sv | 8 +
 rtl/decoder_scan_sequencer_if.sv | 20 ++
 rtl/decoder_4x16.sv | 9 +
 rtl/decoder_scan_sequencer_next_line_finder.sv | 27 ++
 rtl/decoder_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and state encoding for the decoder scan sequencer.
`timescale 1ns/1ps
package decoder_pkg;
    localparam int SEL_W     = 4;
    localparam int NUM_LINES = 16;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} scan_state_t;
endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan requester and the decoder scan sequencer.
`timescale 1ns/1ps
interface decoder_scan_sequencer_if #(parameter int DWELL_W = 8);
    import decoder_pkg::*;

    logic                 start;
    logic                 stop;
    logic                 mode_cont;
    logic [NUM_LINES-1:0] line_mask;
    logic [DWELL_W-1:0]   dwell;
    logic [SEL_W-1:0]     sel_out;
    logic                 en_out;
    logic                 busy;
    logic                 done;

    modport master (output start, stop, mode_cont, line_mask, dwell,
                    input  sel_out, en_out, busy, done);
    modport slave  (input  start, stop, mode_cont, line_mask, dwell,
                    output sel_out, en_out, busy, done);
endinterface

// File: rtl/decoder_4x16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
`timescale 1ns/1ps
module decoder_4x16 (
    input  logic [3:0]  d_in,
    input  logic        en,
    output logic [15:0] y_out
);
    assign y_out = en ? (16'd1 << d_in) : 16'd0;
endmodule

// File: rtl/decoder_scan_sequencer_next_line_finder.sv
// Combinational search for the next set mask bit above cur and the lowest set bit.
`timescale 1ns/1ps
module next_line_finder
    import decoder_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [SEL_W-1:0]     cur,
    output logic [SEL_W-1:0]     nxt,
    output logic                 found_above,
    output logic [SEL_W-1:0]     lowest
);
    // Walk downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        nxt         = '0;
        found_above = 1'b0;
        lowest      = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
                if (i > int'(cur)) begin
                    nxt         = SEL_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scans enabled decoder lines in ascending order with a programmable dwell and a
// fixed blanking gap, so sel_out only moves while en_out is low.
`timescale 1ns/1ps
module decoder_scan_sequencer
    import decoder_pkg::*;
#(
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..255");
    end

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    scan_state_t          state, state_nxt;
    logic [NUM_LINES-1:0] mask_q, find_mask;
    logic [DWELL_W-1:0]   dwell_q, dwell_in_eff, dwell_cnt, dwell_cnt_nxt;
    logic [7:0]           gap_cnt, gap_cnt_nxt;
    logic                 cont_q;
    logic [SEL_W-1:0]     sel_q, sel_nxt, nxt_line, lowest_line;
    logic                 en_q, en_nxt, busy_q, busy_nxt, done_q, done_nxt;
    logic                 found_above, start_ok, dwell_done, gap_done, launch;

    assign dwell_in_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign start_ok     = bus.start && !bus.stop;
    assign launch       = (state == IDLE) && start_ok && (bus.line_mask != '0);
    assign dwell_done   = (dwell_cnt == '0);
    assign gap_done     = (gap_cnt == 8'd0);
    // In IDLE the live mask is searched so the first line is ready at the start edge.
    assign find_mask    = (state == IDLE) ? bus.line_mask : mask_q;

    next_line_finder u_finder (
        .mask        (find_mask),
        .cur         (sel_q),
        .nxt         (nxt_line),
        .found_above (found_above),
        .lowest      (lowest_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            dwell_q   <= '0;
            cont_q    <= 1'b0;
            dwell_cnt <= '0;
            gap_cnt   <= 8'd0;
            sel_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            sel_q     <= sel_nxt;
            en_q      <= en_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            if (launch) begin
                mask_q  <= bus.line_mask;
                dwell_q <= dwell_in_eff;
                cont_q  <= bus.mode_cont;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = DRIVE;
            DRIVE: begin
                if (bus.stop)                     state_nxt = IDLE;
                else if (dwell_done)              state_nxt = (found_above || cont_q) ? GAP : IDLE;
            end
            GAP: begin
                if (bus.stop)                     state_nxt = IDLE;
                else if (gap_done)                state_nxt = DRIVE;
            end
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_nxt       = sel_q;
        en_nxt        = 1'b0;
        done_nxt      = 1'b0;
        busy_nxt      = (state_nxt != IDLE);
        dwell_cnt_nxt = dwell_cnt;
        gap_cnt_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (launch) begin
                    sel_nxt       = lowest_line;
                    en_nxt        = 1'b1;
                    dwell_cnt_nxt = dwell_in_eff - DWELL_W'(1);
                end else if (start_ok) begin
                    done_nxt = 1'b1;
                end
            end
            DRIVE: begin
                if (!bus.stop) begin
                    if (!dwell_done) begin
                        en_nxt        = 1'b1;
                        dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
                    end else if (found_above) begin
                        sel_nxt     = nxt_line;
                        gap_cnt_nxt = GAP_LOAD;
                    end else if (cont_q) begin
                        sel_nxt     = lowest_line;
                        gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!bus.stop) begin
                    if (gap_done) begin
                        en_nxt        = 1'b1;
                        dwell_cnt_nxt = dwell_q - DWELL_W'(1);
                    end else begin
                        gap_cnt_nxt = gap_cnt - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.sel_out = sel_q;
    assign bus.en_out  = en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench: a scan-level model queues expected line visits and done pulses,
// an independent monitor reconstructs them from the outputs and compares.
`timescale 1ns/1ps
module tb_decoder_scan_sequencer;
    localparam int DWELL_W = 8;
    localparam int G       = 1;
    localparam int NOSTOP  = 1 << 30;

    typedef struct {
        bit is_done;
        int sel;
        int t;
        int len;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] y_out;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];
    int          busy_lo = 1;
    int          busy_hi = 0;

    bit          in_run = 0;
    int          run_sel, run_start, run_len;

    decoder_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus();

    decoder_scan_sequencer #(.DWELL_W(DWELL_W), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    decoder_4x16 u_dec (
        .d_in  (bus.sel_out),
        .en    (bus.en_out),
        .y_out (y_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input string detail);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Scan-level reference: lines visited in ascending order, each for max(dwell,1)
    // cycles, G blank cycles between visits; stop_cyc is the last cycle observed busy
    // if the scan is cut short.
    function automatic void gen(input logic [15:0] mask, input int dw, input bit cont,
                                input int s, input int stop_cyc);
        int   lines[$];
        int   d, t, len;
        ev_t  e;
        for (int i = 0; i < 16; i++) if (mask[i]) lines.push_back(i);
        d = (dw == 0) ? 1 : dw;
        if (lines.size() == 0) begin
            e.is_done = 1; e.sel = 0; e.t = s + 1; e.len = 0;
            exp_q.push_back(e);
            busy_lo = 1; busy_hi = 0;
            return;
        end
        t = s + 1;
        busy_lo = t;
        while (t < s + 50000) begin
            for (int j = 0; j < lines.size(); j++) begin
                len = d;
                if (t + d - 1 > stop_cyc) len = stop_cyc - t + 1;
                e.is_done = 0; e.sel = lines[j]; e.t = t; e.len = len;
                exp_q.push_back(e);
                if (len < d) begin busy_hi = stop_cyc; return; end
                t += d;
                if (j == lines.size() - 1 && !cont) begin
                    if (t <= stop_cyc) begin
                        e.is_done = 1; e.sel = 0; e.t = t; e.len = 0;
                        exp_q.push_back(e);
                    end
                    busy_hi = (t - 1 < stop_cyc) ? t - 1 : stop_cyc;
                    return;
                end
                if (stop_cyc < t + G) begin busy_hi = stop_cyc; return; end
                t += G;
            end
        end
    endfunction

    task automatic pop_cmp(input bit is_done, input int sel, input int t, input int len);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk(1'b0, is_done ? "unexpected_done" : "unexpected_line",
                $sformatf("got sel=%0d t=%0d len=%0d, required nothing", sel, t, len));
            return;
        end
        e = exp_q.pop_front();
        chk(e.is_done == is_done && (is_done || (e.sel == sel && e.len == len)) && e.t == t,
            is_done ? "done_event" : "line_event",
            $sformatf("got done=%0d sel=%0d t=%0d len=%0d, required done=%0d sel=%0d t=%0d len=%0d",
                      is_done, sel, t, len, e.is_done, e.sel, e.t, e.len));
    endtask

    // Monitor: samples on the falling edge, rebuilds en_out runs into line events.
    always @(negedge clk) begin
        chk(y_out === ((16'd1 << bus.sel_out) & {16{bus.en_out}}), "y_out",
            $sformatf("got %h, required %h", y_out, (16'd1 << bus.sel_out) & {16{bus.en_out}}));
        chk(bus.busy === (cyc >= busy_lo && cyc <= busy_hi), "busy",
            $sformatf("cyc %0d got %b, required %b", cyc, bus.busy, (cyc >= busy_lo && cyc <= busy_hi)));
        if (bus.en_out === 1'b1) begin
            if (!in_run) begin
                in_run = 1; run_sel = int'(bus.sel_out); run_start = cyc; run_len = 1;
            end else begin
                run_len++;
                chk(int'(bus.sel_out) == run_sel, "sel_stable_while_en",
                    $sformatf("got %0d, required %0d", bus.sel_out, run_sel));
            end
        end else if (in_run) begin
            in_run = 0;
            pop_cmp(1'b0, run_sel, run_start, run_len);
        end
        if (bus.done === 1'b1) pop_cmp(1'b1, 0, cyc, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && bus.busy === 1'b0) break;
            tick();
        end
        if (i == 4000) begin
            chk(1'b0, "drain_timeout", $sformatf("got %0d pending events, required 0", exp_q.size()));
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic run_scan(input logic [15:0] mask, input int dw, input bit cont,
                            input int stop_after, input bit extra_start);
        int s, stop_cyc, last, d;
        d = (dw == 0) ? 1 : dw;
        s = cyc;
        stop_cyc = (stop_after >= 0) ? s + stop_after : NOSTOP;
        if (extra_start && !(d >= 3 && (stop_after < 0 || stop_after > 2))) extra_start = 0;
        bus.line_mask = mask; bus.dwell = DWELL_W'(dw); bus.mode_cont = cont;
        bus.start = 1'b1; bus.stop = 1'b0;
        gen(mask, dw, cont, s, stop_cyc);
        tick();
        last = (stop_after >= 0) ? stop_cyc : s + 3;
        while (cyc <= last) begin
            bus.start     = extra_start && (cyc == s + 2);
            bus.stop      = (stop_after >= 0) && (cyc == stop_cyc);
            bus.line_mask = 16'($urandom);
            bus.dwell     = DWELL_W'($urandom_range(0, 7));
            bus.mode_cont = 1'($urandom);
            tick();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        drain();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int          dw, sa, k, s;
        bit          cont;
        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0; bus.mode_cont = 0; bus.line_mask = '0; bus.dwell = '0;
        #2;
        chk(bus.sel_out === 4'd0 && bus.en_out === 1'b0 && bus.busy === 1'b0 && bus.done === 1'b0,
            "reset_state", $sformatf("got sel=%0d en=%b busy=%b done=%b, required all 0",
                                     bus.sel_out, bus.en_out, bus.busy, bus.done));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        run_scan(16'h0001, 3, 0, -1, 0);
        run_scan(16'h8421, 2, 0, -1, 0);
        run_scan(16'h8001, 1, 1, 14, 0);
        run_scan(16'h0000, 5, 0, -1, 0);
        run_scan(16'h0C30, 4, 0, 2, 0);
        run_scan(16'h0410, 4, 1, 20, 1);

        // start and stop together from IDLE: nothing may happen
        busy_lo = 1; busy_hi = 0;
        bus.line_mask = 16'h00FF; bus.dwell = 2; bus.start = 1; bus.stop = 1;
        tick();
        bus.start = 0; bus.stop = 0;
        repeat (6) tick();

        // asynchronous reset in the middle of a dwell
        s = cyc;
        bus.line_mask = 16'h0030; bus.dwell = 5; bus.mode_cont = 0; bus.start = 1;
        gen(16'h0030, 5, 0, s, s + 2);
        tick();
        bus.start = 0;
        tick();
        tick();
        k = cyc;
        rst_n = 1'b0;
        #1;
        chk(bus.en_out === 1'b0 && bus.sel_out === 4'd0 && bus.busy === 1'b0,
            "async_reset", $sformatf("cyc %0d got en=%b sel=%0d busy=%b, required 0/0/0",
                                     k, bus.en_out, bus.sel_out, bus.busy));
        tick();
        rst_n = 1'b1;
        drain();
        run_scan(16'h0030, 2, 0, -1, 0);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0:       m = 16'h0;
                1:       m = 16'h1 << $urandom_range(0, 15);
                default: m = 16'($urandom);
            endcase
            dw   = $urandom_range(0, 5);
            cont = ($urandom_range(0, 2) == 0);
            if (m == 16'h0)            sa = -1;
            else if (cont)             sa = $urandom_range(3, 60);
            else if ($urandom_range(0, 3) == 0) sa = $urandom_range(1, 40);
            else                       sa = -1;
            run_scan(m, dw, cont, sa, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
